// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU MEM
// stage and an external loader port; each access is a fixed-latency transaction.
module dmem_arbiter #(
   parameter int MEM_LAT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_req,
   input  logic       cpu_we,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic [7:0] cpu_rdata,
   output logic       cpu_done,
   output logic       cpu_stall,
   input  logic       ext_req,
   input  logic       ext_we,
   input  logic [7:0] ext_addr,
   input  logic [7:0] ext_wdata,
   output logic [7:0] ext_rdata,
   output logic       ext_done,
   output logic       mem_en,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
   typedef enum logic {PORT_CPU, PORT_EXT} port_t;

   state_t     state;
   port_t      owner;
   port_t      last_grant;
   logic [2:0] lat_cnt;
   logic       cur_we;

   logic       grant_valid;
   port_t      grant_port;
   logic       sel_we;
   logic [7:0] sel_addr;
   logic [7:0] sel_wdata;

   assign cpu_stall = cpu_req & ~cpu_done;

   // In DONE only the non-owner may be granted, which gives alternating ports
   // a path straight back to ISSUE.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      grant_valid = 1'b0;
      grant_port  = PORT_CPU;
      case (state)
         S_IDLE: begin
            if (cpu_req && (!ext_req || last_grant == PORT_EXT)) begin
               grant_valid = 1'b1;
               grant_port  = PORT_CPU;
            end else if (ext_req) begin
               grant_valid = 1'b1;
               grant_port  = PORT_EXT;
            end
         end
         S_DONE: begin
            if (owner == PORT_CPU && ext_req) begin
               grant_valid = 1'b1;
               grant_port  = PORT_EXT;
            end else if (owner == PORT_EXT && cpu_req) begin
               grant_valid = 1'b1;
               grant_port  = PORT_CPU;
            end
         end
         default: ;
      endcase
   end

   assign sel_we    = (grant_port == PORT_CPU) ? cpu_we    : ext_we;
   assign sel_addr  = (grant_port == PORT_CPU) ? cpu_addr  : ext_addr;
   assign sel_wdata = (grant_port == PORT_CPU) ? cpu_wdata : ext_wdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         owner      <= PORT_CPU;
         last_grant <= PORT_EXT;
         lat_cnt    <= 3'd0;
         cur_we     <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 8'h00;
         mem_wdata  <= 8'h00;
         cpu_rdata  <= 8'h00;
         ext_rdata  <= 8'h00;
         cpu_done   <= 1'b0;
         ext_done   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register sees
         // the pre-edge values and block ordering cannot change behaviour.
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         cpu_done <= 1'b0;
         ext_done <= 1'b0;
         case (state)
            S_ISSUE: begin
               lat_cnt <= 3'(MEM_LAT);
               state   <= S_WAIT;
            end
            S_WAIT: begin
               lat_cnt <= lat_cnt - 3'd1;
               if (lat_cnt == 3'd1) begin
                  state <= S_DONE;
                  if (owner == PORT_CPU) begin
                     cpu_done <= 1'b1;
                     if (!cur_we) cpu_rdata <= mem_rdata;
                  end else begin
                     ext_done <= 1'b1;
                     if (!cur_we) ext_rdata <= mem_rdata;
                  end
               end
            end
            default: begin
               // IDLE and DONE both grant from the arbitration result.
               if (grant_valid) begin
                  state      <= S_ISSUE;
                  owner      <= grant_port;
                  last_grant <= grant_port;
                  cur_we     <= sel_we;
                  mem_en     <= 1'b1;
                  mem_we     <= sel_we;
                  mem_addr   <= sel_addr;
                  mem_wdata  <= sel_wdata;
               end else begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule
